// File: rtl/fft_input_loader.sv
// ---------------------------------------------------------------------------
// fft_input_loader
//
// Purpose:
//   Collects a stream of complex samples into 8-sample frames for the first
//   stage of an 8-point FFT. Two frame banks (A/B) are used in ping-pong
//   fashion. One bank fills from the input stream while the other presents a
//   complete frame downstream. This sustains one sample per clock when the
//   consumer keeps up.
//
// Configuration:
//   FFT_LOADER_BITREV_EN - when defined, out_k carries sample bitrev3(k) of
//                          the read bank. When undefined (default), out_k
//                          carries sample k (natural order).
//
// Parameters:
//   N         - sample width is W = 2**N bits (two's complement).
//
// Ports:
//   clk                    - single clock, rising-edge active
//   rst                    - synchronous active-high reset
//   in_valid / in_ready    - input sample handshake
//   in_r / in_i            - input sample real / imaginary part
//   out_0_r .. out_7_r     - frame real parts from the read bank
//   out_0_i .. out_7_i     - frame imaginary parts from the read bank
//   out_valid / out_ready  - frame handshake; a frame is released on
//                            out_valid && out_ready
// ---------------------------------------------------------------------------
module fft_input_loader #(
    parameter int N = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [2**N-1:0]   in_r,
    input  logic signed [2**N-1:0]   in_i,
    output logic signed [2**N-1:0]   out_0_r,
    output logic signed [2**N-1:0]   out_1_r,
    output logic signed [2**N-1:0]   out_2_r,
    output logic signed [2**N-1:0]   out_3_r,
    output logic signed [2**N-1:0]   out_4_r,
    output logic signed [2**N-1:0]   out_5_r,
    output logic signed [2**N-1:0]   out_6_r,
    output logic signed [2**N-1:0]   out_7_r,
    output logic signed [2**N-1:0]   out_0_i,
    output logic signed [2**N-1:0]   out_1_i,
    output logic signed [2**N-1:0]   out_2_i,
    output logic signed [2**N-1:0]   out_3_i,
    output logic signed [2**N-1:0]   out_4_i,
    output logic signed [2**N-1:0]   out_5_i,
    output logic signed [2**N-1:0]   out_6_i,
    output logic signed [2**N-1:0]   out_7_i,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int W = 2**N;

    // Frame storage: [bank][sample index]
    logic signed [W-1:0] bank_r_q [2][8];
    logic signed [W-1:0] bank_i_q [2][8];

    logic [1:0] full_q, full_d;
    logic [2:0] widx_q, widx_d;
    logic       wsel_q, wsel_d;
    logic       rsel_q, rsel_d;

    logic xfer;
    logic release_frame;

    // Maps output position k to the sample index within the read bank.
    function automatic logic [2:0] src_idx(input logic [2:0] k);
`ifdef FFT_LOADER_BITREV_EN
        return {k[0], k[1], k[2]};
`else
        return k;
`endif
    endfunction

    // in_ready depends only on registered state (plus rst). It never depends
    // on out_ready. A bank being released this cycle therefore only becomes
    // writable on the next cycle. This keeps the input path free of
    // combinational paths from downstream.
    assign in_ready      = !rst && !full_q[wsel_q];
    assign out_valid     = full_q[rsel_q];
    assign xfer          = in_valid && in_ready;
    assign release_frame = out_valid && out_ready;

    always_comb begin
        full_d = full_q;
        widx_d = widx_q;
        wsel_d = wsel_q;
        rsel_d = rsel_q;

        if (release_frame) begin
            full_d[rsel_q] = 1'b0;
            rsel_d         = ~rsel_q;
        end

        // Applied after the release so that a completing write always marks
        // its bank full, even when both events occur in the same cycle.
        if (xfer) begin
            widx_d = widx_q + 3'd1;
            if (widx_q == 3'd7) begin
                full_d[wsel_q] = 1'b1;
                wsel_d         = ~wsel_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 2'b00;
            widx_q <= 3'd0;
            wsel_q <= 1'b0;
            rsel_q <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < 8; k++) begin
                    bank_r_q[b][k] <= '0;
                    bank_i_q[b][k] <= '0;
                end
            end
        end else begin
            full_q <= full_d;
            widx_q <= widx_d;
            wsel_q <= wsel_d;
            rsel_q <= rsel_d;
            if (xfer) begin
                bank_r_q[wsel_q][widx_q] <= in_r;
                bank_i_q[wsel_q][widx_q] <= in_i;
            end
        end
    end

    assign out_0_r = bank_r_q[rsel_q][src_idx(3'd0)];
    assign out_1_r = bank_r_q[rsel_q][src_idx(3'd1)];
    assign out_2_r = bank_r_q[rsel_q][src_idx(3'd2)];
    assign out_3_r = bank_r_q[rsel_q][src_idx(3'd3)];
    assign out_4_r = bank_r_q[rsel_q][src_idx(3'd4)];
    assign out_5_r = bank_r_q[rsel_q][src_idx(3'd5)];
    assign out_6_r = bank_r_q[rsel_q][src_idx(3'd6)];
    assign out_7_r = bank_r_q[rsel_q][src_idx(3'd7)];

    assign out_0_i = bank_i_q[rsel_q][src_idx(3'd0)];
    assign out_1_i = bank_i_q[rsel_q][src_idx(3'd1)];
    assign out_2_i = bank_i_q[rsel_q][src_idx(3'd2)];
    assign out_3_i = bank_i_q[rsel_q][src_idx(3'd3)];
    assign out_4_i = bank_i_q[rsel_q][src_idx(3'd4)];
    assign out_5_i = bank_i_q[rsel_q][src_idx(3'd5)];
    assign out_6_i = bank_i_q[rsel_q][src_idx(3'd6)];
    assign out_7_i = bank_i_q[rsel_q][src_idx(3'd7)];

endmodule
